// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared constants for the nibble-serial adder: state encoding, slice width, default size.
// No logic lives here; imported by the interface, adder slice and sequencer.
package serial_add_pkg;

    localparam int NIB_W       = 4;
    localparam int NIBBLES_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Index counter is never narrower than one bit, even for a single slice.
    function automatic int idx_width(input int nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_ctrl_if.sv
// Requester-side bundle for the nibble-serial adder: start/operands in, busy/done/result out.
// Optional SERIAL_ADD_SUB_EN adds the sub request bit and the ovf result bit.
interface nibble_serial_adder_ctrl_if
    import serial_add_pkg::*;
#(
    parameter int NIBBLES = NIBBLES_DEF
);
    localparam int W = NIB_W * NIBBLES;

    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Cin;
    logic         busy;
    logic         done;
    logic [W-1:0] Sum;
    logic         Cout;
`ifdef SERIAL_ADD_SUB_EN
    logic         sub;
    logic         ovf;

    modport master (output start, A, B, Cin, sub, input busy, done, Sum, Cout, ovf);
    modport slave  (input start, A, B, Cin, sub, output busy, done, Sum, Cout, ovf);
`else
    modport master (output start, A, B, Cin, input busy, done, Sum, Cout);
    modport slave  (input start, A, B, Cin, output busy, done, Sum, Cout);
`endif

endinterface

// File: rtl/nibble_serial_adder_ctrl_four_bit_adder.sv
// four_bit_adder: purely combinational 4-bit ripple-carry adder, the shared datapath slice.
// Zero latency; no handshake.
module four_bit_adder
    import serial_add_pkg::*;
(
    input  logic [NIB_W-1:0] a_i,
    input  logic [NIB_W-1:0] b_i,
    input  logic             cin_i,
    output logic [NIB_W-1:0] sum_o,
    output logic             cout_o
);

    logic [NIB_W:0] c;

    assign c[0] = cin_i;

    for (genvar i = 0; i < NIB_W; i++) begin : g_bit
        assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
        assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end

    assign cout_o = c[NIB_W];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Wide add through one shared 4-bit adder, one nibble per cycle LSB first; done NIBBLES+1 cycles after start.
// start is ignored (not queued) outside IDLE; SERIAL_ADD_SUB_EN enables subtract and signed overflow.
module nibble_serial_adder_ctrl
    import serial_add_pkg::*;
#(
    parameter int NIBBLES = NIBBLES_DEF
)(
    input  logic                          clk,
    input  logic                          rst_n,
    nibble_serial_adder_ctrl_if.slave     bus
);

    localparam int W     = NIB_W * NIBBLES;
    localparam int IDX_W = idx_width(NIBBLES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic [W-1:0]     a_q,     a_d;
    logic [W-1:0]     b_q,     b_d;
    logic             carry_q, carry_d;
    logic [W-1:0]     sum_q,   sum_d;
    logic             cout_q,  cout_d;
`ifdef SERIAL_ADD_SUB_EN
    logic             ovf_q,   ovf_d;
`endif

    logic [NIB_W-1:0] a_nib;
    logic [NIB_W-1:0] b_nib;
    logic [NIB_W-1:0] add_sum;
    logic             add_cout;

    assign a_nib = a_q[idx_q*NIB_W +: NIB_W];
    assign b_nib = b_q[idx_q*NIB_W +: NIB_W];

    four_bit_adder u_adder (
        .a_i    (a_nib),
        .b_i    (b_nib),
        .cin_i  (carry_q),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADD_SUB_EN
        ovf_d   = ovf_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.A;
                    idx_d   = '0;
                    state_d = ST_RUN;
`ifdef SERIAL_ADD_SUB_EN
                    // Subtract as A + ~B + 1; Cin is deliberately ignored here.
                    b_d     = bus.sub ? ~bus.B : bus.B;
                    carry_d = bus.sub ? 1'b1   : bus.Cin;
`else
                    b_d     = bus.B;
                    carry_d = bus.Cin;
`endif
                end
            end
            ST_RUN: begin
                sum_d[idx_q*NIB_W +: NIB_W] = add_sum;
                carry_d = add_cout;
                if (idx_q == IDX_LAST) begin
                    cout_d  = add_cout;
                    state_d = ST_DONE;
`ifdef SERIAL_ADD_SUB_EN
                    ovf_d   = (a_nib[NIB_W-1] == b_nib[NIB_W-1]) &&
                              (add_sum[NIB_W-1] != a_nib[NIB_W-1]);
`endif
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ADD_SUB_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.busy = (state_q == ST_RUN);
    assign bus.done = (state_q == ST_DONE);
    assign bus.Sum  = sum_q;
    assign bus.Cout = cout_q;
`ifdef SERIAL_ADD_SUB_EN
    assign bus.ovf  = ovf_q;
`endif

endmodule
